// File: rtl/gray_ptr_decoder.sv
// gray_ptr_decoder
//   Receive side of a binary->gray crossing. A gray-coded value arriving from
//   another clock domain is re-timed through a SYNC_STAGES flop chain,
//   decoded to binary on every change, and announced with a one-cycle
//   bin_valid strobe.
//
//   Optional feature macro: STEP_CHECK_EN
//     defined   -> step_err pulses with bin_valid when a change flips more
//                  than one gray bit (except on the first update after reset)
//     undefined -> step_err is tied low and the step-check logic is absent
module gray_ptr_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_err
);

  // Synchronizer chain: plain flop-to-flop, nothing in between
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] gray_s;
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] diff;
  logic             upd;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Shift the asynchronous input through the synchronizer every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign gray_s = sync_q[SYNC_STAGES-1];

  // Change detection against the previous synchronized sample
  always_comb begin
    diff = gray_s ^ prev_gray;
    upd  = |diff;
  end

  // Remember the last synchronized sample so the next change can be detected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray <= '0;
    end else begin
      prev_gray <= gray_s;
    end
  end

  // Decode and strobe on every change; hold the last value otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out   <= '0;
      bin_valid <= 1'b0;
    end else begin
      bin_valid <= upd;
      if (upd) begin
        bin_out <= gray2bin(gray_s);
      end
    end
  end

`ifdef STEP_CHECK_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] flip_cnt;
  logic             multi_flip;
  logic             first_upd_done;

  // Count how many gray bits flipped in this sample
  always_comb begin
    flip_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip_cnt = flip_cnt + CNT_W'(diff[i]);
    end
    multi_flip = (flip_cnt > CNT_W'(1));
  end

  // The first change after reset has no trusted predecessor, so it is never flagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_upd_done <= 1'b0;
    end else if (upd) begin
      first_upd_done <= 1'b1;
    end
  end

  // Illegal-step pulse, aligned with the bin_valid of the same update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_err <= 1'b0;
    end else begin
      step_err <= upd & first_upd_done & multi_flip;
    end
  end
`else
  assign step_err = 1'b0;
`endif

endmodule
